vdec_hs_scch_sel: RTL and testbench

HS-SCCH candidate selection controller for the HS Viterbi decoding path. For each configured HS-SCCH candidate (up to four), it runs the Viterbi decoder on part 1 and then the symbol-error-rate (SER) stage on the decoded bits. It keeps the candidate with the lowest SER and declares a detection when that SER is at or below a programmable threshold. The block sits above the Viterbi core and the SER stage and drives both through start/done handshakes.

---
 rtl/vdec_hs_scch_sel.sv | 154 +++++++++++++++
 tb/tb_vdec_hs_scch_sel.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vdec_hs_scch_sel.sv
// rtl/vdec_hs_scch_sel.sv - HS-SCCH candidate selection over Viterbi + SER stages.
// Optional early exit on a zero SER: VDEC_HS_SCCH_SEL_EARLY_EXIT_EN.
module vdec_hs_scch_sel (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  cand_num,
    input  logic [35:0] cand_base,
    input  logic [6:0]  ser_thr,
    output logic        busy,
    output logic        done,
    output logic        det_hit,
    output logic [1:0]  det_idx,
    output logic [7:0]  det_bits,
    output logic [6:0]  det_ser,
    output logic        vit_start,
    output logic [8:0]  vit_base,
    input  logic        vit_done,
    input  logic [7:0]  vit_bits,
    output logic        ser_start,
    output logic [8:0]  ser_base,
    output logic [28:0] ser_dec_bits,
    output logic [1:0]  ser_hs_mode,
    output logic [5:0]  ser_cbs_p7,
    input  logic        ser_done,
    input  logic [6:0]  ser_acc
);

`ifdef VDEC_HS_SCCH_SEL_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, VIT, VIT_W, SER, SER_W, NXT, FIN} state_t;

    state_t      state;
    logic [2:0]  num_r;
    logic [35:0] base_r;
    logic [6:0]  thr_r;
    logic [1:0]  k;
    logic [7:0]  bits_k;
    logic [6:0]  best_ser;
    logic [1:0]  best_idx;
    logic [7:0]  best_bits;
    logic        stop;
    logic [2:0]  num_clamped;

    function automatic logic [8:0] base_of(input logic [35:0] b, input logic [1:0] i);
        logic [8:0] r;
        case (i)
            2'd0:    r = b[8:0];
            2'd1:    r = b[17:9];
            2'd2:    r = b[26:18];
            default: r = b[35:27];
        endcase
        return r;
    endfunction

    assign num_clamped  = (cand_num > 3'd4) ? 3'd4 : cand_num;
    assign busy         = (state != IDLE);
    assign ser_dec_bits = {21'd0, bits_k};
    assign ser_hs_mode  = 2'b00;
    assign ser_cbs_p7   = 6'd15;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            num_r     <= 3'd0;
            base_r    <= 36'd0;
            thr_r     <= 7'd0;
            k         <= 2'd0;
            bits_k    <= 8'd0;
            best_ser  <= 7'h7F;
            best_idx  <= 2'd0;
            best_bits <= 8'd0;
            stop      <= 1'b0;
            done      <= 1'b0;
            det_hit   <= 1'b0;
            det_idx   <= 2'd0;
            det_bits  <= 8'd0;
            det_ser   <= 7'h7F;
            vit_start <= 1'b0;
            vit_base  <= 9'd0;
            ser_start <= 1'b0;
            ser_base  <= 9'd0;
        end else begin
            vit_start <= 1'b0;
            ser_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_r     <= num_clamped;
                        base_r    <= cand_base;
                        thr_r     <= ser_thr;
                        k         <= 2'd0;
                        best_ser  <= 7'h7F;
                        best_idx  <= 2'd0;
                        best_bits <= 8'd0;
                        stop      <= 1'b0;
                        // An empty run passes through NXT so done lands two cycles after start.
                        if (num_clamped == 3'd0) begin
                            state <= NXT;
                        end else begin
                            state     <= VIT;
                            vit_start <= 1'b1;
                            vit_base  <= cand_base[8:0];
                        end
                    end
                end
                VIT: state <= VIT_W;
                VIT_W: begin
                    if (vit_done) begin
                        bits_k    <= vit_bits;
                        ser_start <= 1'b1;
                        ser_base  <= base_of(base_r, k);
                        state     <= SER;
                    end
                end
                SER: state <= SER_W;
                SER_W: begin
                    if (ser_done) begin
                        if (ser_acc < best_ser) begin
                            best_ser  <= ser_acc;
                            best_idx  <= k;
                            best_bits <= bits_k;
                        end
                        stop  <= EARLY_EXIT && (ser_acc == 7'd0);
                        state <= NXT;
                    end
                end
                NXT: begin
                    if (!stop && (({1'b0, k} + 3'd1) < num_r)) begin
                        k         <= k + 2'd1;
                        vit_base  <= base_of(base_r, k + 2'd1);
                        vit_start <= 1'b1;
                        state     <= VIT;
                    end else begin
                        det_hit  <= (num_r != 3'd0) && (best_ser <= thr_r);
                        det_idx  <= best_idx;
                        det_bits <= best_bits;
                        det_ser  <= best_ser;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdec_hs_scch_sel.sv
// tb/tb_vdec_hs_scch_sel.sv - directed self-checking bench for vdec_hs_scch_sel.
module tb_vdec_hs_scch_sel;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  cand_num = 3'd0;
    logic [35:0] cand_base = 36'd0;
    logic [6:0]  ser_thr = 7'd0;
    logic        busy, done, det_hit;
    logic [1:0]  det_idx;
    logic [7:0]  det_bits;
    logic [6:0]  det_ser;
    logic        vit_start;
    logic [8:0]  vit_base;
    logic        vit_done = 1'b0;
    logic [7:0]  vit_bits = 8'd0;
    logic        ser_start;
    logic [8:0]  ser_base;
    logic [28:0] ser_dec_bits;
    logic [1:0]  ser_hs_mode;
    logic [5:0]  ser_cbs_p7;
    logic        ser_done = 1'b0;
    logic [6:0]  ser_acc = 7'd0;

    int checks = 0;
    int errors = 0;
    int vit_cnt = 0;
    int ser_cnt = 0;
    int done_cnt = 0;
    int vb_wr = 0;
    logic [8:0] vb_log [16];
    int v0, s0, d0;

    vdec_hs_scch_sel dut (
        .clk(clk), .rst(rst), .start(start), .cand_num(cand_num),
        .cand_base(cand_base), .ser_thr(ser_thr), .busy(busy), .done(done),
        .det_hit(det_hit), .det_idx(det_idx), .det_bits(det_bits), .det_ser(det_ser),
        .vit_start(vit_start), .vit_base(vit_base), .vit_done(vit_done), .vit_bits(vit_bits),
        .ser_start(ser_start), .ser_base(ser_base), .ser_dec_bits(ser_dec_bits),
        .ser_hs_mode(ser_hs_mode), .ser_cbs_p7(ser_cbs_p7), .ser_done(ser_done), .ser_acc(ser_acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vit_start === 1'b1) begin
            vit_cnt <= vit_cnt + 1;
            vb_log[vb_wr & 15] <= vit_base;
            vb_wr <= vb_wr + 1;
        end
        if (ser_start === 1'b1) ser_cnt <= ser_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [2:0] n, input logic [35:0] b, input logic [6:0] t);
        cand_num = n; cand_base = b; ser_thr = t; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Acts as Viterbi and SER stage for one candidate; leaves the bench in cycle u+1.
    task automatic respond(input logic [7:0] vb, input logic [6:0] sa, input bit spurious);
        int n = 0;
        while (vit_start !== 1'b1 && n < 40) begin tick(); n++; end
        chk("vit_start_seen", vit_start, 1);
        tick(); tick();
        vit_bits = vb; vit_done = 1'b1;
        tick();
        vit_done = 1'b0;
        chk("ser_start_lat", ser_start, 1);
        chk("ser_dec_bits", ser_dec_bits, {21'd0, vb});
        tick();
        if (spurious) begin
            vit_bits = 8'hEE; vit_done = 1'b1;
            tick();
        end
        ser_acc = sa; ser_done = 1'b1;
        tick();
        ser_done = 1'b0; vit_done = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_det_ser", det_ser, 7'h7F);
        chk("rst_det_hit", det_hit, 0);
        chk("rst_vit_start", vit_start, 0);
        chk("hs_mode", ser_hs_mode, 0);
        chk("cbs_p7", ser_cbs_p7, 15);

        // Run 1: SER 12, 5, 9 with thr 6 -> candidate 1 wins.
        v0 = vit_cnt; s0 = ser_cnt;
        start_run(3'd3, {9'd0, 9'd30, 9'd20, 9'd10}, 7'd6);
        chk("r1_vit_start_c1", vit_start, 1);
        chk("r1_vit_base0", vit_base, 10);
        respond(8'hA1, 7'd12, 0);
        respond(8'hB2, 7'd5, 0);
        respond(8'hC3, 7'd9, 0);
        tick();
        chk("r1_done", done, 1);
        chk("r1_hit", det_hit, 1);
        chk("r1_idx", det_idx, 1);
        chk("r1_ser", det_ser, 5);
        chk("r1_bits", det_bits, 8'hB2);
        tick();
        chk("r1_busy_fall", busy, 0);
        chk("r1_vit_cnt", vit_cnt - v0, 3);
        chk("r1_ser_cnt", ser_cnt - s0, 3);

        // Run 2: tie 7, 7 keeps index 0, above threshold.
        start_run(3'd2, {18'd0, 9'd50, 9'd40}, 7'd6);
        respond(8'h11, 7'd7, 0);
        respond(8'h22, 7'd7, 0);
        tick();
        chk("r2_done", done, 1);
        chk("r2_idx", det_idx, 0);
        chk("r2_ser", det_ser, 7);
        chk("r2_hit", det_hit, 0);
        chk("r2_bits", det_bits, 8'h11);
        tick();

        // Run 3: no candidates.
        v0 = vit_cnt; s0 = ser_cnt;
        start_run(3'd0, 36'd0, 7'h7F);
        chk("r3_busy_c1", busy, 1);
        chk("r3_done_c1", done, 0);
        tick();
        chk("r3_done_c2", done, 1);
        chk("r3_hit", det_hit, 0);
        chk("r3_ser", det_ser, 7'h7F);
        chk("r3_idx", det_idx, 0);
        tick();
        chk("r3_busy_c3", busy, 0);
        chk("r3_no_vit", vit_cnt - v0, 0);
        chk("r3_no_ser", ser_cnt - s0, 0);

        // Run 4: clamp 7 -> 4, restart and spurious vit_done ignored.
        v0 = vit_cnt; s0 = ser_cnt; vb_wr = 0;
        start_run(3'd7, {9'd400, 9'd300, 9'd200, 9'd100}, 7'd15);
        respond(8'h01, 7'd20, 0);
        cand_num = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        respond(8'h02, 7'd10, 1);
        respond(8'h03, 7'd10, 1);
        respond(8'h04, 7'd30, 0);
        tick();
        chk("r4_done", done, 1);
        chk("r4_idx", det_idx, 1);
        chk("r4_bits", det_bits, 8'h02);
        chk("r4_hit", det_hit, 1);
        tick();
        chk("r4_vit_cnt", vit_cnt - v0, 4);
        chk("r4_ser_cnt", ser_cnt - s0, 4);
        chk("r4_vb0", vb_log[0], 100);
        chk("r4_vb1", vb_log[1], 200);
        chk("r4_vb2", vb_log[2], 300);
        chk("r4_vb3", vb_log[3], 400);

        // Run 5: reset during SER_W, then a clean run.
        start_run(3'd2, {18'd0, 9'd7, 9'd6}, 7'd6);
        tick(); tick();
        vit_bits = 8'h55; vit_done = 1'b1;
        tick();
        vit_done = 1'b0;
        tick(); tick();
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("r5_busy_rst", busy, 0);
        chk("r5_det_ser_rst", det_ser, 7'h7F);
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("r5_no_done", done_cnt - d0, 0);
        start_run(3'd1, {27'd0, 9'd9}, 7'd6);
        respond(8'h77, 7'd4, 0);
        tick();
        chk("r5_done", done, 1);
        chk("r5_hit", det_hit, 1);
        chk("r5_ser", det_ser, 4);
        chk("r5_bits", det_bits, 8'h77);
        tick();
        chk("r5_done_cnt", done_cnt - d0, 1);

        // Run 6: SER 3 then 0.
        v0 = vit_cnt;
        start_run(3'd4, {9'd4, 9'd3, 9'd2, 9'd1}, 7'd6);
        respond(8'h61, 7'd3, 0);
        respond(8'h62, 7'd0, 0);
`ifndef VDEC_HS_SCCH_SEL_EARLY_EXIT_EN
        respond(8'h63, 7'd5, 0);
        respond(8'h64, 7'd6, 0);
`endif
        tick();
        chk("r6_done", done, 1);
        chk("r6_idx", det_idx, 1);
        chk("r6_ser", det_ser, 0);
        chk("r6_bits", det_bits, 8'h62);
        tick();
`ifdef VDEC_HS_SCCH_SEL_EARLY_EXIT_EN
        chk("r6_vit_cnt", vit_cnt - v0, 2);
`else
        chk("r6_vit_cnt", vit_cnt - v0, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
